// File: rtl/formula_result_sink_if.sv
// formula_result_sink_if: result stream, credit and status signals between the pipeline side and formula_result_sink
//   arg_issue, res_vld, res, out_rdy             : driven by the environment (master)
//   credit_ok, out_vld, out_data, occupancy,
//   in_flight, err_ovf, err_orphan, err_credit   : driven by the sink (slave)
interface formula_result_sink_if #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 8
);
    logic                       arg_issue;
    logic                       credit_ok;
    logic                       res_vld;
    logic [FLEN-1:0]            res;
    logic                       out_vld;
    logic [FLEN-1:0]            out_data;
    logic                       out_rdy;
    logic [$clog2(DEPTH):0]     occupancy;
    logic [$clog2(DEPTH):0]     in_flight;
    logic                       err_ovf;
    logic                       err_orphan;
    logic                       err_credit;

    modport master (
        output arg_issue, res_vld, res, out_rdy,
        input  credit_ok, out_vld, out_data, occupancy, in_flight, err_ovf, err_orphan, err_credit
    );
    modport slave (
        input  arg_issue, res_vld, res, out_rdy,
        output credit_ok, out_vld, out_data, occupancy, in_flight, err_ovf, err_orphan, err_credit
    );
endinterface

// File: rtl/formula_result_sink.sv
// formula_result_sink: credit-guarded FIFO sink for a non-stallable result pipeline
//   clk, rst : clock, asynchronous active-high reset
//   bus      : formula_result_sink_if.slave (issue/credit, result input, valid/ready output, counters, sticky errors)
module formula_result_sink #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    formula_result_sink_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_V = CW'(DEPTH);
    localparam logic [CW:0]   LIMIT  = (CW+1)'(DEPTH);

    logic [FLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   occ, infl;
    logic [CW:0]     committed;
    logic            push, pop, full, wr_en;
    logic            ovf, orphan, bad_credit;

    // Results already in flight plus stored ones may never exceed the FIFO size.
    assign committed      = {1'b0, infl} + {1'b0, occ};
    assign bus.credit_ok  = committed < LIMIT;
    assign full           = occ == FULL_V;
    assign push           = bus.res_vld;
    assign pop            = bus.out_vld && bus.out_rdy;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign wr_en          = push && (!full || pop);
    assign bus.out_vld    = occ != '0;
    assign bus.out_data   = mem[rd_ptr];
    assign bus.occupancy  = occ;
    assign bus.in_flight  = infl;
    assign bus.err_ovf    = ovf;
    assign bus.err_orphan = orphan;
    assign bus.err_credit = bad_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            infl       <= '0;
            ovf        <= 1'b0;
            orphan     <= 1'b0;
            bad_credit <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            occ        <= occ + CW'(wr_en) - CW'(pop);
            infl       <= (bus.arg_issue && !bus.res_vld && infl != FULL_V) ? infl + CW'(1) :
                          (bus.res_vld && !bus.arg_issue && infl != '0)   ? infl - CW'(1) : infl;
            ovf        <= ovf | (push && full && !pop);
            orphan     <= orphan | (bus.res_vld && !bus.arg_issue && infl == '0);
            bad_credit <= bad_credit | (bus.arg_issue && !bus.credit_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.res;
    end
endmodule
